analog_sample_ctrl: RTL and testbench
=====================================

# analog_sample_ctrl

Periodic acquisition controller that sits directly upstream of the analog I/O port block and consumes its read data. Strobes the I/O block's enable in read direction at a programmable interval, accumulates 2^AVG_LOG2 consecutive samples, and presents the truncated mean on a valid/ready output to the processing logic. Results that arrive while the previous one is still pending overwrite it and set a sticky overrun flag.

## Interface
- BITS, 16, sample width; matches the I/O block's data width
- AVG_LOG2, 2, log2 of samples averaged per result (0 = pass-through, each sample is a result)
- PERIOD_W, 16, width of the sample-interval input
- clk  input  1  the standard clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run acquisition; low aborts and returns to IDLE
- period  input  PERIOD_W  idle cycles inserted before each sample strobe
- io_en  output  1  enable to the I/O block (one-cycle strobe)
- io_dir  output  1  direction to the I/O block; always 0 (read)
- io_data_in  output  BITS  write data to the I/O block; always 0
- io_data_out  input  BITS  captured pin value from the I/O block
- avg_data  output  BITS  averaged result
- avg_valid  output  1  avg_data holds an unconsumed result
- avg_ready  input  1  consumer accepts avg_data when high with avg_valid
- overrun  output  1  sticky: a pending result was overwritten

## Operation
- Reset values: io_en=0, io_dir=0, io_data_in=0, avg_data=0, avg_valid=0, overrun=0; FSM in IDLE, accumulator, sample count and period counter all 0.
- FSM states: IDLE, WAIT, SAMPLE, CAPTURE.
- IDLE: when enable=1 -> WAIT; the period counter is loaded with `period`.
- WAIT: decrement the counter; leave for SAMPLE on the cycle it reads 0. If period=0, go straight to SAMPLE.
- SAMPLE: io_en=1 for exactly this cycle; the I/O block registers the pin on this edge -> CAPTURE.
- CAPTURE: io_data_out now holds the new sample. Add it to the accumulator (width BITS+AVG_LOG2, no overflow possible) and increment the sample count.
  - If the count reaches 2^AVG_LOG2: avg_data <= (acc+sample) >> AVG_LOG2 (truncating), avg_valid <= 1, and accumulator and count clear.
  - Then -> WAIT with the counter reloaded from `period`.
- Output handshake: a transfer occurs on a cycle with avg_valid && avg_ready, after which avg_valid <= 0. avg_data is stable while avg_valid=1 unless an overrun replaces it.
- Simultaneous handshake and new result in the same cycle: the new result wins (avg_valid stays 1, avg_data updates); overrun is NOT set.
- New result while avg_valid=1 and avg_ready=0: overwrite avg_data and set overrun=1.
- overrun clears only on rst_n or while enable=0.
- enable falling in any state: next cycle FSM=IDLE, io_en=0, accumulator and count cleared (partial average discarded). avg_valid/avg_data are untouched and the pending result can still be consumed.
- Asynchronous reset mid-operation returns everything to reset values immediately.

## Timing
- Strobe cadence: period+2 cycles between successive io_en pulses (WAIT period, SAMPLE 1, CAPTURE 1).
- Latency from IDLE with enable rising: first io_en after period+1 cycles.
- Latency from the io_en of the final sample to avg_valid high: 2 edges (I/O capture, then CAPTURE update).
- A result is produced every 2^AVG_LOG2 × (period+2) cycles.
- `period` is sampled only on entry to WAIT; changes mid-WAIT take effect next interval.

## Configuration
- ANALOG_SAMPLE_MINMAX_EN defined: adds outputs min_data and max_data (BITS each). They hold the minimum and maximum raw sample of the averaging window that produced the current avg_data, and update together with avg_data. Reset value is 0.
- Without the macro: those ports and their registers do not exist; all other behaviour is identical.

## Structure
- Shared package analog_pkg:
  - FSM state typedef (IDLE, WAIT, SAMPLE, CAPTURE)
  - default BITS constant, shared with the I/O block
- One sub-module, sample_accum: accumulator, sample count, divide and optional min/max. It takes clear/add strobes and a sample, and returns a done pulse plus the result.
- Top level holds the FSM, period counter and output handshake registers.

## Test plan
- Reset then enable=1, period=3, AVG_LOG2=2, pin samples 10,20,30,41 -> io_en pulses 5 cycles apart; avg_data=25, avg_valid=1, overrun=0.
- period=0 -> io_en high every 2nd cycle, never two consecutive cycles.
- avg_ready held 0 across two results (first 100, second 200) -> avg_data=200, overrun=1. Then drop enable for one cycle -> overrun=0.
- avg_ready=1 on the exact cycle the next result lands -> avg_valid stays 1, avg_data=new value, overrun stays 0.
- enable dropped after 2 of 4 samples, then re-enabled with samples 8,8,8,8 -> avg_data=8 (partial samples discarded).
- rst_n asserted during SAMPLE -> io_en=0 immediately and all outputs at reset values; with ANALOG_SAMPLE_MINMAX_EN and samples 5,9,1,7 -> min_data=1, max_data=9, avg_data=5.

Source files
------------

// File: rtl/analog_pkg.sv
// Types shared by the analog acquisition path: sequencer state encoding and
// the data width of the analog I/O port block.
package analog_pkg;

   localparam int ANALOG_BITS = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      SAMPLE  = 2'd2,
      CAPTURE = 2'd3
   } analog_state_t;

endpackage

// File: rtl/analog_sample_ctrl_if.sv
// Averaged-result stream from analog_sample_ctrl to the processing logic.
// Optional min_data/max_data exist only with ANALOG_SAMPLE_MINMAX_EN defined.
interface analog_sample_ctrl_if #(
   parameter int BITS = analog_pkg::ANALOG_BITS
);

   // valid/ready: avg_data transfers on a rising clk edge where avg_valid and
   // avg_ready are both high; avg_valid stays up until that edge, and avg_data
   // only changes meanwhile when a newer result overwrites it (overrun).
   logic [BITS-1:0] avg_data;
   logic            avg_valid;
   logic            avg_ready;
   logic            overrun;
`ifdef ANALOG_SAMPLE_MINMAX_EN
   logic [BITS-1:0] min_data;
   logic [BITS-1:0] max_data;
`endif

   modport master (
      input  avg_ready,
      output avg_data, avg_valid, overrun
`ifdef ANALOG_SAMPLE_MINMAX_EN
      , output min_data, max_data
`endif
   );

   modport slave (
      output avg_ready,
      input  avg_data, avg_valid, overrun
`ifdef ANALOG_SAMPLE_MINMAX_EN
      , input min_data, max_data
`endif
   );

endinterface

// File: rtl/analog_sample_ctrl_sample_accum.sv
// Window accumulator: sums 2^AVG_LOG2 samples and emits the truncated mean.
// With ANALOG_SAMPLE_MINMAX_EN it also tracks the window's min and max.
module sample_accum
   import analog_pkg::*;
#(
   parameter int BITS     = ANALOG_BITS,
   parameter int AVG_LOG2 = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            add,
   input  logic [BITS-1:0] sample,
   output logic            done,
   output logic [BITS-1:0] result
`ifdef ANALOG_SAMPLE_MINMAX_EN
   ,
   output logic [BITS-1:0] min_res,
   output logic [BITS-1:0] max_res
`endif
);

   localparam int ACC_W = BITS + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic [ACC_W-1:0] sum;

   // done/result are combinational on the closing add so the caller can
   // register the mean on the same edge the last sample is absorbed.
   assign sum    = acc + ACC_W'(sample);
   assign done   = add && !clear && (count == LAST_IDX);
   assign result = BITS'(sum >> AVG_LOG2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         count <= '0;
      end else if (clear || done) begin
         acc   <= '0;
         count <= '0;
      end else if (add) begin
         acc   <= sum;
         count <= count + CNT_W'(1);
      end
   end

`ifdef ANALOG_SAMPLE_MINMAX_EN
   logic [BITS-1:0] run_min;
   logic [BITS-1:0] run_max;
   logic [BITS-1:0] min_next;
   logic [BITS-1:0] max_next;

   // The first sample of a window seeds both trackers, so no explicit clear.
   assign min_next = ((count == '0) || (sample < run_min)) ? sample : run_min;
   assign max_next = ((count == '0) || (sample > run_max)) ? sample : run_max;
   assign min_res  = min_next;
   assign max_res  = max_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_min <= '0;
         run_max <= '0;
      end else if (add && !clear) begin
         run_min <= min_next;
         run_max <= max_next;
      end
   end
`endif

endmodule

// File: rtl/analog_sample_ctrl.sv
// Periodic acquisition controller in front of the analog I/O port block.
// Define ANALOG_SAMPLE_MINMAX_EN to add min_data/max_data to the result stream.
module analog_sample_ctrl
   import analog_pkg::*;
#(
   parameter int BITS     = ANALOG_BITS,
   parameter int AVG_LOG2 = 2,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   output logic                io_en,
   output logic                io_dir,
   output logic [BITS-1:0]     io_data_in,
   input  logic [BITS-1:0]     io_data_out,
   analog_sample_ctrl_if.master res,
   output analog_state_t       state_dbg
);

   analog_state_t       state;
   logic [PERIOD_W-1:0] period_cnt;
   logic                acc_add;
   logic                acc_clear;
   logic                acc_done;
   logic [BITS-1:0]     acc_result;
`ifdef ANALOG_SAMPLE_MINMAX_EN
   logic [BITS-1:0]     acc_min;
   logic [BITS-1:0]     acc_max;
`endif

   assign io_dir     = 1'b0;
   assign io_data_in = '0;
   assign state_dbg  = state;
   assign acc_add    = enable && (state == CAPTURE);
   assign acc_clear  = !enable;

   // Sequencer. WAIT spans exactly `period` cycles: it exits on the cycle
   // the counter steps to zero, and a zero period skips WAIT entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         period_cnt <= '0;
         io_en      <= 1'b0;
      end else if (!enable) begin
         state      <= IDLE;
         period_cnt <= '0;
         io_en      <= 1'b0;
      end else begin
         io_en <= 1'b0;
         case (state)
            IDLE, CAPTURE: begin
               if (period == '0) begin
                  state <= SAMPLE;
                  io_en <= 1'b1;
               end else begin
                  state      <= WAIT;
                  period_cnt <= period;
               end
            end
            WAIT: begin
               period_cnt <= period_cnt - PERIOD_W'(1);
               if (period_cnt == PERIOD_W'(1)) begin
                  state <= SAMPLE;
                  io_en <= 1'b1;
               end
            end
            SAMPLE:  state <= CAPTURE;
            default: state <= IDLE;
         endcase
      end
   end

   sample_accum #(
      .BITS     (BITS),
      .AVG_LOG2 (AVG_LOG2)
   ) u_accum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (acc_clear),
      .add     (acc_add),
      .sample  (io_data_out),
      .done    (acc_done),
      .result  (acc_result)
`ifdef ANALOG_SAMPLE_MINMAX_EN
      ,
      .min_res (acc_min),
      .max_res (acc_max)
`endif
   );

   // A new result always wins over a same-cycle transfer; it only counts as
   // an overrun when the pending result was not being taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res.avg_data  <= '0;
         res.avg_valid <= 1'b0;
         res.overrun   <= 1'b0;
`ifdef ANALOG_SAMPLE_MINMAX_EN
         res.min_data  <= '0;
         res.max_data  <= '0;
`endif
      end else begin
         if (acc_done) begin
            res.avg_data  <= acc_result;
            res.avg_valid <= 1'b1;
`ifdef ANALOG_SAMPLE_MINMAX_EN
            res.min_data  <= acc_min;
            res.max_data  <= acc_max;
`endif
         end else if (res.avg_valid && res.avg_ready) begin
            res.avg_valid <= 1'b0;
         end

         if (!enable) begin
            res.overrun <= 1'b0;
         end else if (acc_done && res.avg_valid && !res.avg_ready) begin
            res.overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_analog_sample_ctrl.sv
// Directed bench for analog_sample_ctrl with a small model of the I/O block
// that returns queued pin values on each io_en strobe.
module tb_analog_sample_ctrl;
   import analog_pkg::*;

   localparam int BITS     = 16;
   localparam int AVG_LOG2 = 2;
   localparam int PERIOD_W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                enable;
   logic [PERIOD_W-1:0] period;
   logic                io_en;
   logic                io_dir;
   logic [BITS-1:0]     io_data_in;
   logic [BITS-1:0]     io_data_out = '0;
   analog_state_t       state_dbg;

   analog_sample_ctrl_if #(.BITS(BITS)) res_if ();

   analog_sample_ctrl #(
      .BITS     (BITS),
      .AVG_LOG2 (AVG_LOG2),
      .PERIOD_W (PERIOD_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .period      (period),
      .io_en       (io_en),
      .io_dir      (io_dir),
      .io_data_in  (io_data_in),
      .io_data_out (io_data_out),
      .res         (res_if),
      .state_dbg   (state_dbg)
   );

   // I/O block model: registers the next pin value on the strobe edge
   logic [BITS-1:0] pin_q[$];
   always @(posedge clk) begin
      if (io_en) begin
         if (pin_q.size() > 0) io_data_out <= pin_q.pop_front();
         else                  io_data_out <= '0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- scoreboard / driver tasks ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push4(input int a, input int b, input int c, input int d);
      pin_q.push_back(BITS'(a));
      pin_q.push_back(BITS'(b));
      pin_q.push_back(BITS'(c));
      pin_q.push_back(BITS'(d));
   endtask

   task automatic wait_io_en(input string tag, output int t);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (io_en !== 1'b1 && k < 40);
      chk(tag, 32'(io_en), 32'd1);
      t = cyc;
   endtask

   task automatic wait_valid(input string tag, input int max_cyc);
      int k;
      k = 0;
      while (res_if.avg_valid !== 1'b1 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(res_if.avg_valid), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t0, t1, t2, k;
      rst_n            = 1'b0;
      enable           = 1'b0;
      period           = 16'd3;
      res_if.avg_ready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_io_en",      32'(io_en), 0);
      chk("rst_io_dir",     32'(io_dir), 0);
      chk("rst_io_data_in", 32'(io_data_in), 0);
      chk("rst_avg_data",   32'(res_if.avg_data), 0);
      chk("rst_avg_valid",  32'(res_if.avg_valid), 0);
      chk("rst_overrun",    32'(res_if.overrun), 0);
      chk("rst_state",      32'(state_dbg), 32'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // period=3: 10,20,30,41 -> mean 25, strobes 5 apart
      push4(10, 20, 30, 41);
      enable = 1'b1;
      t0 = cyc;
      wait_io_en("a_first_strobe", t1);
      chk("a_first_latency", 32'(t1 - t0), 4);
      for (int i = 0; i < 3; i++) begin
         wait_io_en("a_strobe", t2);
         chk("a_strobe_gap", 32'(t2 - t1), 5);
         t1 = t2;
      end
      @(negedge clk);
      chk("a_valid_after_1_edge", 32'(res_if.avg_valid), 0);
      @(negedge clk);
      chk("a_valid_after_2_edges", 32'(res_if.avg_valid), 1);
      chk("a_avg_data",  32'(res_if.avg_data), 25);
      chk("a_overrun",   32'(res_if.overrun), 0);
      chk("a_state",     32'(state_dbg), 32'(WAIT));
      res_if.avg_ready = 1'b1;
      @(negedge clk);
      chk("a_consumed",  32'(res_if.avg_valid), 0);
      res_if.avg_ready = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      chk("a_abort_state", 32'(state_dbg), 32'(IDLE));
      chk("a_abort_io_en", 32'(io_en), 0);

      // period=0: strobe every other cycle; 1,2,3,6 -> 3
      pin_q.delete();
      period = 16'd0;
      res_if.avg_ready = 1'b1;
      push4(1, 2, 3, 6);
      enable = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         chk("b_io_en_pattern", 32'(io_en), 32'(i % 2));
      end
      chk("b_avg_data",  32'(res_if.avg_data), 3);
      chk("b_avg_valid", 32'(res_if.avg_valid), 0);
      chk("b_overrun",   32'(res_if.overrun), 0);
      enable = 1'b0;
      res_if.avg_ready = 1'b0;
      @(negedge clk);

      // two results with no consumer -> overwrite + overrun
      pin_q.delete();
      period = 16'd1;
      push4(100, 100, 100, 100);
      push4(200, 200, 200, 200);
      enable = 1'b1;
      wait_valid("c_first_valid", 40);
      chk("c_first_data",    32'(res_if.avg_data), 100);
      chk("c_first_overrun", 32'(res_if.overrun), 0);
      k = 0;
      while (res_if.overrun !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("c_overrun_set", 32'(res_if.overrun), 1);
      chk("c_second_data", 32'(res_if.avg_data), 200);
      chk("c_still_valid", 32'(res_if.avg_valid), 1);
      enable = 1'b0;
      @(negedge clk);
      chk("c_overrun_cleared", 32'(res_if.overrun), 0);
      chk("c_valid_kept",      32'(res_if.avg_valid), 1);
      chk("c_data_kept",       32'(res_if.avg_data), 200);
      res_if.avg_ready = 1'b1;
      @(negedge clk);
      chk("c_consumed", 32'(res_if.avg_valid), 0);
      res_if.avg_ready = 1'b0;

      // transfer on the same edge a new result lands: 40 then 61
      pin_q.delete();
      push4(40, 40, 40, 40);
      push4(60, 60, 60, 64);
      enable = 1'b1;
      wait_valid("d_first_valid", 40);
      chk("d_first_data", 32'(res_if.avg_data), 40);
      for (int i = 0; i < 4; i++) wait_io_en("d_strobe", t2);
      @(negedge clk);
      chk("d_pending_valid", 32'(res_if.avg_valid), 1);
      chk("d_pending_data",  32'(res_if.avg_data), 40);
      res_if.avg_ready = 1'b1;
      @(negedge clk);
      chk("d_new_valid",   32'(res_if.avg_valid), 1);
      chk("d_new_data",    32'(res_if.avg_data), 61);
      chk("d_no_overrun",  32'(res_if.overrun), 0);
      enable = 1'b0;
      @(negedge clk);
      chk("d_consumed", 32'(res_if.avg_valid), 0);
      res_if.avg_ready = 1'b0;

      // abort after 2 of 4 samples, then a clean 8,8,8,8 window
      pin_q.delete();
      pin_q.push_back(BITS'(90));
      pin_q.push_back(BITS'(90));
      enable = 1'b1;
      wait_io_en("e_strobe1", t2);
      wait_io_en("e_strobe2", t2);
      @(negedge clk);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("e_abort_state", 32'(state_dbg), 32'(IDLE));
      pin_q.delete();
      push4(8, 8, 8, 8);
      enable = 1'b1;
      wait_valid("e_valid", 40);
      chk("e_avg_data", 32'(res_if.avg_data), 8);
      chk("e_overrun",  32'(res_if.overrun), 0);
      res_if.avg_ready = 1'b1;
      @(negedge clk);
      chk("e_consumed", 32'(res_if.avg_valid), 0);
      res_if.avg_ready = 1'b0;
      enable = 1'b0;
      @(negedge clk);

      // async reset while in SAMPLE
      pin_q.delete();
      period = 16'd2;
      push4(5, 9, 1, 7);
      enable = 1'b1;
      wait_io_en("f_strobe", t2);
      chk("f_in_sample", 32'(state_dbg), 32'(SAMPLE));
      rst_n = 1'b0;
      #1;
      chk("f_rst_io_en",     32'(io_en), 0);
      chk("f_rst_state",     32'(state_dbg), 32'(IDLE));
      chk("f_rst_avg_data",  32'(res_if.avg_data), 0);
      chk("f_rst_avg_valid", 32'(res_if.avg_valid), 0);
      chk("f_rst_overrun",   32'(res_if.overrun), 0);
`ifdef ANALOG_SAMPLE_MINMAX_EN
      chk("f_rst_min", 32'(res_if.min_data), 0);
      chk("f_rst_max", 32'(res_if.max_data), 0);
`endif
      enable = 1'b0;
      pin_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push4(5, 9, 1, 7);
      enable = 1'b1;
      wait_valid("f_valid", 60);
      chk("f_avg_data", 32'(res_if.avg_data), 5);
`ifdef ANALOG_SAMPLE_MINMAX_EN
      chk("f_min_data", 32'(res_if.min_data), 1);
      chk("f_max_data", 32'(res_if.max_data), 9);
`endif
      enable = 1'b0;
      @(negedge clk);

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
